cu_sequencer: RTL

Control-unit sequencer directly downstream of the instruction register (IR). Consumes the 16-bit instruction the IR presents on `to_cu`, runs a multi-cycle fetch/decode/execute state machine, and drives the IR's `write_en`/`read_en`, the memory `rd`/`wr` strobes, PC/MAR load controls, register-file write selects and ALU opcode. Memory accesses use a ready handshake, so the sequencer stalls on slow memory.

---
 rtl/cu_pkg.sv | 49 ++++
 rtl/cu_decode.sv | 42 ++++
 rtl/cu_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared opcodes, FSM states and encodings
// for the control-unit sequencer and its decoder.
package cu_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_MOV   = 4'h6;
  localparam logic [3:0] OP_LDI   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] BUS_PC  = 2'd0;
  localparam logic [1:0] BUS_IMM = 2'd1;
  localparam logic [1:0] BUS_REG = 2'd2;
  localparam logic [1:0] BUS_ALU = 2'd3;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_AND  = 2'd2;
  localparam logic [1:0] ALU_PASS = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH_A,
    S_FETCH_B,
    S_DECODE,
    S_EXEC,
    S_MEM_A,
    S_MEM_RD,
    S_MEM_WR,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_LDI,
    C_JMP,
    C_JZ,
    C_LOAD,
    C_STORE,
    C_HALT
  } iclass_t;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: opcode -> instruction class, ALU op, illegal.
// Ports: op_i opcode; cls_o class; alu_op_o; illegal_o.
module cu_decode
  import cu_pkg::*;
(
  input  logic [3:0] op_i,
  output iclass_t    cls_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o     = C_NOP;
    alu_op_o  = ALU_PASS;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_NOP:   cls_o = C_NOP;
      OP_LOAD:  cls_o = C_LOAD;
      OP_STORE: cls_o = C_STORE;
      OP_ADD: begin
        cls_o    = C_ALU;
        alu_op_o = ALU_ADD;
      end
      OP_SUB: begin
        cls_o    = C_ALU;
        alu_op_o = ALU_SUB;
      end
      OP_AND: begin
        cls_o    = C_ALU;
        alu_op_o = ALU_AND;
      end
      OP_MOV:   cls_o = C_ALU;
      OP_LDI:   cls_o = C_LDI;
      OP_JMP:   cls_o = C_JMP;
      OP_JZ:    cls_o = C_JZ;
      OP_HALT:  cls_o = C_HALT;
      // A..E run as NOP but are flagged
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle fetch/decode/execute control FSM.
// Ports: clk, reset (sync, high); to_cu instr from IR;
// mem_ready, z_flag in; IR/mem/PC/MAR/regfile/ALU controls,
// halted, illegal out.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] to_cu,
  input  logic              mem_ready,
  input  logic              z_flag,
  output logic              ir_write_en,
  output logic              ir_read_en,
  output logic              rd,
  output logic              wr,
  output logic              mar_we,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [1:0]        bus_sel,
  output logic [NREG-1:0]   reg_we,
  output logic [1:0]        alu_op,
  output logic              halted,
  output logic              illegal
);

  state_t state_q, state_d;

  iclass_t    cls;
  logic [1:0] dec_alu;
  logic       dec_ill;

  logic [NREG-1:0] rd_oh;

  // rs and imm/addr are consumed by the datapath
  logic unused_fields;
  assign unused_fields = ^to_cu[9:0];

  assign rd_oh = NREG'(1) << to_cu[11:10];

  cu_decode u_dec (
    .op_i      (to_cu[15:12]),
    .cls_o     (cls),
    .alu_op_o  (dec_alu),
    .illegal_o (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH_A;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ir_write_en = 1'b0;
    ir_read_en  = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    mar_we      = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    bus_sel     = BUS_PC;
    reg_we      = '0;
    alu_op      = ALU_ADD;
    halted      = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      S_FETCH_A: begin
        mar_we  = 1'b1;
        state_d = S_FETCH_B;
      end
      S_FETCH_B: begin
        rd = 1'b1;
        if (mem_ready) begin
          ir_write_en = 1'b1;
          pc_inc      = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        illegal = dec_ill;
        unique case (cls)
          C_NOP:   state_d = S_FETCH_A;
          C_HALT:  state_d = S_HALT;
          C_LOAD,
          C_STORE: state_d = S_MEM_A;
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH_A;
        unique case (cls)
          C_ALU: begin
            bus_sel = BUS_ALU;
            alu_op  = dec_alu;
            reg_we  = rd_oh;
          end
          C_LDI: begin
            ir_read_en = 1'b1;
            bus_sel    = BUS_IMM;
            reg_we     = rd_oh;
          end
          C_JMP, C_JZ: begin
            ir_read_en = 1'b1;
            bus_sel    = BUS_IMM;
            pc_load    = (cls == C_JMP) | z_flag;
          end
          default: ;
        endcase
      end
      S_MEM_A: begin
        ir_read_en = 1'b1;
        bus_sel    = BUS_IMM;
        mar_we     = 1'b1;
        state_d    = (cls == C_STORE) ? S_MEM_WR
                                      : S_MEM_RD;
      end
      S_MEM_RD: begin
        rd = 1'b1;
        if (mem_ready) begin
          reg_we  = rd_oh;
          state_d = S_FETCH_A;
        end
      end
      S_MEM_WR: begin
        wr      = 1'b1;
        bus_sel = BUS_REG;
        if (mem_ready) state_d = S_FETCH_A;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH_A;
    endcase

    // Held reset silences every control, so a strobe
    // already in flight can never complete a write.
    if (reset) begin
      ir_write_en = 1'b0;
      ir_read_en  = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      mar_we      = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      bus_sel     = BUS_PC;
      reg_we      = '0;
      alu_op      = ALU_ADD;
      halted      = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule
